fu_br_pipe: RTL
===============

# fu_br_pipe

Parametrised branch functional unit for the out-of-order core. It resolves conditional, unconditional and indirect branches and compares each outcome against the fetch-stage prediction, raising a one-cycle recovery request on a mispredict. Results queue in an OUT_DEPTH-deep buffer ahead of CDB/ROB writeback. In-flight and buffered ops younger than a squashing branch are discarded.

## Interface
- XLEN, 64, operand/PC width
- PRF_IDX_W, 6, physical register tag width
- ROB_IDX_W, 5, ROB index width; ROB tags carry one extra wrap bit (ROB_IDX_W+1 bits)
- OUT_DEPTH, 2, result buffer entries; must be ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  issue valid
- ready_o  out  1  unit can accept an issue this cycle
- npc_i  in  XLEN  PC+4 of the branch
- opa_i  in  XLEN  regA value
- inst_i  in  32  instruction word
- dest_tag_i  in  PRF_IDX_W  link destination tag
- rob_idx_i  in  ROB_IDX_W+1  ROB tag of the branch
- pred_taken_i  in  1  predicted direction
- pred_target_i  in  XLEN  predicted target
- rob_head_i  in  ROB_IDX_W+1  current ROB head tag (age reference)
- squash_i  in  1  external squash
- squash_idx_i  in  ROB_IDX_W+1  squash ops strictly younger than this tag
- valid_o  out  1  buffer head valid
- grant_i  in  1  CDB grant; pops head when valid_o=1
- taken_o, wr_en_o  out  1  resolved direction; link write enable
- link_o  out  XLEN  link value (npc)
- dest_tag_o  out  PRF_IDX_W
- rob_idx_o  out  ROB_IDX_W+1
- mispred_o  out  1  entry was mispredicted
- recov_valid_o  out  1  recovery pulse
- recov_target_o  out  XLEN  correct next PC
- recov_rob_idx_o  out  ROB_IDX_W+1  tag of mispredicting branch

## Operation
- Decode on inst_i[31:26]: 6'h1A (JMP/JSR/RET/JSR_CO): taken, target = {opa_i[XLEN-1:2],2'b00}, wr_en=1. 6'h30 BR, 6'h34 BSR: taken, target = npc_i + sext(inst_i[20:0])<<2, wr_en=1. 6'h38–6'h3F: conditional on func=inst_i[28:26]: func[1:0] 00 opa[0]==0, 01 opa==0, 10 opa[XLEN-1], 11 opa[XLEN-1]|opa==0; func[2] inverts; wr_en=0. Any other opcode: not taken, wr_en=0, mispred only if pred_taken_i.
- Target arithmetic modulo 2^XLEN. Actual next PC = taken ? target : npc_i.
- mispred = (taken != pred_taken_i) | (taken & target != pred_target_i).
- Accept when start_i & ready_o & ~(squash_i & younger(rob_idx_i)).
- younger(x): (x - rob_head_i) > (squash_idx_i - rob_head_i), unsigned, ROB_IDX_W+1-bit wrap.
- On squash_i, every buffer entry with younger(rob_idx) is invalidated the same cycle; survivors keep order, compacting toward head.
- Pending recovery pulse is suppressed if its branch is itself younger than a same-cycle squash.

## Timing
- Reset: all outputs 0; ready_o=1 from first cycle after rst_n deassert; buffer empty.
- Accept at cycle T → entry visible at head no earlier than T+1; recov_* pulses exactly at T+1 for one cycle if mispredicted, independent of buffer position.
- ready_o = buffer not full, from registered count only (no comb path from grant_i).
- Pop at edge where valid_o & grant_i; simultaneous push and pop permitted; count unchanged.
- Full: ready_o=0; start_i ignored. Empty: valid_o=0, payload outputs hold last value or 0 (don't-care).
- Squash coinciding with push and pop: pop first, then squash filter, then push of surviving input.
- rst_n assertion mid-operation clears buffer and pending recovery immediately (async).

## Structure
- Shared package: opcode constants (BR, BSR, JMP group, cond range), cond-func enum, ROB-tag age-compare function, ROB/PRF width constants.
- Sub-module br_cond_eval: combinational condition evaluator (opa, func → cond).
- Buffer is an in-module shift-compacting array, OUT_DEPTH entries.

## Test plan
- BEQ (6'h39) opa=0, pred_taken=1, pred_target correct → taken_o=1, mispred_o=0, no recov pulse at T+1.
- BNE (6'h3D) opa=5, pred_taken=0 → taken=1, recov_valid_o at T+1, recov_target_o=npc+disp·4.
- JSR opa=0x1003, pred_target=0x2000 → target 0x1000, wr_en_o=1, link_o=npc_i, mispred=1.
- Issue 3 ops with grant_i=0, OUT_DEPTH=2 → ready_o=0 after 2nd accept, 3rd held; grant releases in order.
- Buffer holds tags 3,4 (head 2), squash_idx=3 → tag 4 removed, tag 3 kept; head-wrap variant with tags 31/0 wrap bit flipped.
- rst_n low mid-burst → valid_o, recov_valid_o drop to 0 asynchronously; ready_o=1 after release.

Source files
------------

// File: rtl/fu_br_pipe_pkg.sv
// Shared definitions for the branch functional unit: widths, opcode
// encodings, condition-function enum and the ROB-tag age comparison.
package fu_br_pipe_pkg;

  localparam int unsigned XLEN_DEF      = 64;
  localparam int unsigned PRF_IDX_W_DEF = 6;
  localparam int unsigned ROB_IDX_W_DEF = 5;

  localparam logic [5:0] OP_JMP_GRP  = 6'h1A;
  localparam logic [5:0] OP_BR       = 6'h30;
  localparam logic [5:0] OP_BSR      = 6'h34;
  localparam logic [2:0] OP_COND_PFX = 3'b111;  // 6'h38..6'h3F

  typedef enum logic [1:0] {
    COND_LBC = 2'b00,
    COND_EQ  = 2'b01,
    COND_LT  = 2'b10,
    COND_LE  = 2'b11
  } cond_func_e;

  // Distances from the ROB head are compared modulo 2^tag_w, so the wrap bit
  // in the tag makes ages unambiguous across head wrap-around.
  function automatic logic rob_younger(input logic [31:0] tag,
                                       input logic [31:0] head,
                                       input logic [31:0] sq,
                                       input int unsigned tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return ((tag - head) & mask) > ((sq - head) & mask);
  endfunction

endpackage

// File: rtl/fu_br_pipe_cond_eval.sv
// Combinational conditional-branch evaluator: opa value and func field
// in, branch condition out.
module br_cond_eval
  import fu_br_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] opa_i,
  input  logic [2:0]      func_i,
  output logic            cond_o
);

  cond_func_e kind;
  logic       base;

  always_comb begin
    kind = cond_func_e'(func_i[1:0]);
    base = 1'b0;
    case (kind)
      COND_LBC: base = ~opa_i[0];
      COND_EQ:  base = (opa_i == '0);
      COND_LT:  base = opa_i[XLEN-1];
      COND_LE:  base = opa_i[XLEN-1] | (opa_i == '0);
      default:  base = 1'b0;
    endcase
    cond_o = base ^ func_i[2];
  end

endmodule

// File: rtl/fu_br_pipe.sv
// Branch functional unit: resolves branches, flags mispredicts with a
// one-cycle recovery pulse and queues results for CDB writeback.
module fu_br_pipe
  import fu_br_pipe_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned PRF_IDX_W = PRF_IDX_W_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [XLEN-1:0]      npc_i,
  input  logic [XLEN-1:0]      opa_i,
  input  logic [31:0]          inst_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic                 pred_taken_i,
  input  logic [XLEN-1:0]      pred_target_i,
  input  logic [ROB_IDX_W:0]   rob_head_i,
  input  logic                 squash_i,
  input  logic [ROB_IDX_W:0]   squash_idx_i,
  output logic                 valid_o,
  input  logic                 grant_i,
  output logic                 taken_o,
  output logic                 wr_en_o,
  output logic [XLEN-1:0]      link_o,
  output logic [PRF_IDX_W-1:0] dest_tag_o,
  output logic [ROB_IDX_W:0]   rob_idx_o,
  output logic                 mispred_o,
  output logic                 recov_valid_o,
  output logic [XLEN-1:0]      recov_target_o,
  output logic [ROB_IDX_W:0]   recov_rob_idx_o
);

  localparam int unsigned TAG_W = ROB_IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic                 taken;
    logic                 wr_en;
    logic [XLEN-1:0]      link;
    logic [PRF_IDX_W-1:0] dest_tag;
    logic [ROB_IDX_W:0]   rob_idx;
    logic                 mispred;
  } ent_t;

  logic [5:0]      opcode;
  logic            cond;
  logic            taken;
  logic            wr_en;
  logic            mispred;
  logic [XLEN-1:0] disp;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            unused_ra;

  assign opcode    = inst_i[31:26];
  assign unused_ra = ^inst_i[25:21];

  br_cond_eval #(.XLEN(XLEN)) u_cond (
    .opa_i  (opa_i),
    .func_i (inst_i[28:26]),
    .cond_o (cond)
  );

  always_comb begin
    disp   = {{(XLEN-23){inst_i[20]}}, inst_i[20:0], 2'b00};
    taken  = 1'b0;
    wr_en  = 1'b0;
    target = npc_i + disp;
    if (opcode == OP_JMP_GRP) begin
      taken  = 1'b1;
      wr_en  = 1'b1;
      target = {opa_i[XLEN-1:2], 2'b00};
    end else if (opcode == OP_BR || opcode == OP_BSR) begin
      taken = 1'b1;
      wr_en = 1'b1;
    end else if (opcode[5:3] == OP_COND_PFX) begin
      taken = cond;
    end
    next_pc = taken ? target : npc_i;
    mispred = (taken != pred_taken_i) | (taken & (target != pred_target_i));
  end

  logic [31:0] head32;
  logic [31:0] sq32;
  logic        in_younger;
  logic        recov_younger;
  logic        accept;

  ent_t              buf_q [OUT_DEPTH];
  ent_t              buf_d [OUT_DEPTH];
  ent_t              new_ent;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              recov_valid_q, recov_valid_d;
  logic [XLEN-1:0]   recov_target_q, recov_target_d;
  logic [ROB_IDX_W:0] recov_rob_idx_q, recov_rob_idx_d;
  logic              pop;
  logic              keep;
  int unsigned       occ;
  int unsigned       k;

  assign head32        = 32'(rob_head_i);
  assign sq32          = 32'(squash_idx_i);
  assign in_younger    = rob_younger(32'(rob_idx_i), head32, sq32, TAG_W);
  assign recov_younger = rob_younger(32'(recov_rob_idx_q), head32, sq32, TAG_W);
  assign accept        = start_i & ready_q & ~(squash_i & in_younger);

  always_comb begin
    new_ent          = '0;
    new_ent.taken    = taken;
    new_ent.wr_en    = wr_en;
    new_ent.link     = npc_i;
    new_ent.dest_tag = dest_tag_i;
    new_ent.rob_idx  = rob_idx_i;
    new_ent.mispred  = mispred;
  end

  // Pop, then squash filter, then push: surviving entries are packed toward
  // slot 0 in order and the accepted op lands in the first free slot.
  always_comb begin
    for (int unsigned j = 0; j < OUT_DEPTH; j++) buf_d[j] = '0;
    pop  = (count_q != '0) & grant_i;
    occ  = 32'(count_q);
    k    = 0;
    keep = 1'b0;
    for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
      keep = (i < occ) && !(pop && (i == 0)) &&
             !(squash_i && rob_younger(32'(buf_q[i].rob_idx), head32, sq32, TAG_W));
      if (keep) begin
        for (int unsigned j = 0; j < OUT_DEPTH; j++)
          if (j == k) buf_d[j] = buf_q[i];
        k = k + 1;
      end
    end
    if (accept) begin
      for (int unsigned j = 0; j < OUT_DEPTH; j++)
        if (j == k) buf_d[j] = new_ent;
      k = k + 1;
    end
    count_d = CNT_W'(k);
    ready_d = (k < OUT_DEPTH);
  end

  always_comb begin
    recov_valid_d   = accept & mispred;
    recov_target_d  = recov_target_q;
    recov_rob_idx_d = recov_rob_idx_q;
    if (accept) begin
      recov_target_d  = next_pc;
      recov_rob_idx_d = rob_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) buf_q[i] <= '0;
      count_q         <= '0;
      ready_q         <= 1'b0;
      recov_valid_q   <= 1'b0;
      recov_target_q  <= '0;
      recov_rob_idx_q <= '0;
    end else begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) buf_q[i] <= buf_d[i];
      count_q         <= count_d;
      ready_q         <= ready_d;
      recov_valid_q   <= recov_valid_d;
      recov_target_q  <= recov_target_d;
      recov_rob_idx_q <= recov_rob_idx_d;
    end
  end

  assign ready_o         = ready_q;
  assign valid_o         = (count_q != '0);
  assign taken_o         = buf_q[0].taken;
  assign wr_en_o         = buf_q[0].wr_en;
  assign link_o          = buf_q[0].link;
  assign dest_tag_o      = buf_q[0].dest_tag;
  assign rob_idx_o       = buf_q[0].rob_idx;
  assign mispred_o       = buf_q[0].mispred;
  assign recov_valid_o   = recov_valid_q & ~(squash_i & recov_younger);
  assign recov_target_o  = recov_target_q;
  assign recov_rob_idx_o = recov_rob_idx_q;

endmodule
